// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Contents:
//  - Forwarding muxes for operands A and B.
//  - A combinational ALU that produces alu_result, zero, write_reg and store_data.
//  - An iterative multiply/divide unit that owns the architectural HI/LO registers.
// The mul/div unit retires BITS_PC bits per cycle. It stalls the upstream stages only
// when a later HI/LO consumer reaches EX while an operation is still running.
module ex_stage #(
    parameter int DATA_W  = 32,
    parameter int BITS_PC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ex_ctrl,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic [DATA_W-1:0] sign_extend,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic [DATA_W-1:0] wb_fwd_data,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] store_data,
    output logic [4:0]        write_reg,
    output logic              zero,
    output logic              md_stall,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int N     = DATA_W / BITS_PC;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_OR    = 2'b11;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_t;

    // Decoded control fields
    logic              w_reg_dst;
    logic              w_alu_src;
    logic [1:0]        w_alu_op;

    // Operands and ALU
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;
    logic              w_slt;
    logic              w_sltu;

    // Mul/div control
    md_state_t         r_state;
    md_state_t         w_state_nxt;
    logic              w_md_op;
    logic              w_md_any;
    logic              w_md_start;
    logic              w_md_finish;

    // Operand capture at issue
    logic              w_signed;
    logic              w_op_div;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;

    // Mul/div working registers
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_acc_hi;
    logic [DATA_W-1:0] r_acc_lo;
    logic [DATA_W-1:0] r_opd;
    logic              r_is_div;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic              r_div_zero;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    // Per-cycle iteration results
    logic [DATA_W-1:0]   w_step_hi;
    logic [DATA_W-1:0]   w_step_lo;
    logic [DATA_W:0]     w_t_rem;
    logic [DATA_W-1:0]   w_t_diff;
    logic [DATA_W:0]     w_t_sum;
    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_prod_s;
    logic [DATA_W-1:0]   w_fin_hi;
    logic [DATA_W-1:0]   w_fin_lo;

    assign w_reg_dst = ex_ctrl[3];
    assign w_alu_src = ex_ctrl[2];
    assign w_alu_op  = ex_ctrl[1:0];

    // Forwarding mux for operand A (both 00 and 11 select the register value)
    always_comb begin
        w_a = reg1;
        case (fwd_a)
            2'b01:   w_a = wb_fwd_data;
            2'b10:   w_a = mem_fwd_data;
            default: w_a = reg1;
        endcase
    end

    // Forwarding mux for operand B, then the immediate select
    always_comb begin
        w_fwd_b = reg2;
        case (fwd_b)
            2'b01:   w_fwd_b = wb_fwd_data;
            2'b10:   w_fwd_b = mem_fwd_data;
            default: w_fwd_b = reg2;
        endcase
        if (w_alu_src) begin
            w_b = sign_extend;
        end else begin
            w_b = w_fwd_b;
        end
    end

    assign w_slt  = ($signed(w_a) < $signed(w_b));
    assign w_sltu = (w_a < w_b);

    // ALU: arithmetic wraps; mul/div and unknown functs produce zero
    always_comb begin
        w_alu = {DATA_W{1'b0}};
        case (w_alu_op)
            OP_ADD: w_alu = w_a + w_b;
            OP_SUB: w_alu = w_a - w_b;
            OP_OR:  w_alu = w_a | w_b;
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: w_alu = w_a + w_b;
                    F_SUB, F_SUBU: w_alu = w_a - w_b;
                    F_AND:   w_alu = w_a & w_b;
                    F_OR:    w_alu = w_a | w_b;
                    F_XOR:   w_alu = w_a ^ w_b;
                    F_NOR:   w_alu = ~(w_a | w_b);
                    F_SLT:   w_alu = {{(DATA_W-1){1'b0}}, w_slt};
                    F_SLTU:  w_alu = {{(DATA_W-1){1'b0}}, w_sltu};
                    F_SLL:   w_alu = w_b << shamt;
                    F_SRL:   w_alu = w_b >> shamt;
                    F_SRA:   w_alu = $signed(w_b) >>> shamt;
                    F_MFHI:  w_alu = r_hi;
                    F_MFLO:  w_alu = r_lo;
                    default: w_alu = {DATA_W{1'b0}};
                endcase
            end
            default: w_alu = {DATA_W{1'b0}};
        endcase
    end

    assign alu_result = w_alu;
    assign zero       = (w_alu == {DATA_W{1'b0}});
    assign store_data = w_fwd_b;
    assign write_reg  = w_reg_dst ? rd : rt;
    assign hi         = r_hi;
    assign lo         = r_lo;

    // Classify the instruction in EX for the mul/div unit
    always_comb begin
        w_md_op  = 1'b0;
        w_md_any = 1'b0;
        if (w_alu_op == OP_RTYPE) begin
            w_md_op  = (funct == F_MULT) || (funct == F_MULTU) ||
                       (funct == F_DIV)  || (funct == F_DIVU);
            w_md_any = w_md_op || (funct == F_MFHI) || (funct == F_MFLO);
        end else begin
            w_md_op  = 1'b0;
            w_md_any = 1'b0;
        end
    end

    // Mul/div FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mul/div FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_md_op) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Mul/div FSM: outputs. Only a second HI/LO user stalls; the issuer itself flows on.
    always_comb begin
        w_md_start  = (r_state == S_IDLE) && w_md_op;
        w_md_finish = (r_state == S_RUN) && (r_cnt == CNT_LAST);
        md_stall    = (r_state == S_RUN) && w_md_any;
    end

    // Sign handling at issue: iterate on magnitudes and fix the signs when writing HI/LO
    always_comb begin
        w_signed = (funct == F_MULT) || (funct == F_DIV);
        w_op_div = funct[1];
        w_a_neg  = w_signed & w_a[DATA_W-1];
        w_b_neg  = w_signed & w_b[DATA_W-1];
        w_a_mag  = w_a_neg ? (~w_a + {{(DATA_W-1){1'b0}}, 1'b1}) : w_a;
        w_b_mag  = w_b_neg ? (~w_b + {{(DATA_W-1){1'b0}}, 1'b1}) : w_b;
    end

    // One cycle of iteration.
    // MUL is shift-add: acc_lo starts as the multiplier and acc_hi collects partial sums.
    // DIV is restoring: acc_lo shifts the dividend out and the quotient bits in.
    always_comb begin
        w_step_hi = r_acc_hi;
        w_step_lo = r_acc_lo;
        w_t_rem   = {(DATA_W+1){1'b0}};
        w_t_diff  = {DATA_W{1'b0}};
        w_t_sum   = {(DATA_W+1){1'b0}};
        for (int k = 0; k < BITS_PC; k++) begin
            if (r_is_div) begin
                w_t_rem  = {w_step_hi, w_step_lo[DATA_W-1]};
                w_t_diff = w_t_rem[DATA_W-1:0] - r_opd;
                if (w_t_rem >= {1'b0, r_opd}) begin
                    w_step_hi = w_t_diff;
                    w_step_lo = {w_step_lo[DATA_W-2:0], 1'b1};
                end else begin
                    w_step_hi = w_t_rem[DATA_W-1:0];
                    w_step_lo = {w_step_lo[DATA_W-2:0], 1'b0};
                end
            end else begin
                if (w_step_lo[0]) begin
                    w_t_sum = {1'b0, w_step_hi} + {1'b0, r_opd};
                end else begin
                    w_t_sum = {1'b0, w_step_hi};
                end
                w_step_lo = {w_t_sum[0], w_step_lo[DATA_W-1:1]};
                w_step_hi = w_t_sum[DATA_W:1];
            end
        end
    end

    // Final HI/LO values. The remainder follows the dividend sign, which also makes
    // HI reproduce A on a divide by zero.
    always_comb begin
        w_prod   = {w_step_hi, w_step_lo};
        w_prod_s = r_neg_res ? (~w_prod + {{(2*DATA_W-1){1'b0}}, 1'b1}) : w_prod;
        w_fin_hi = w_prod_s[2*DATA_W-1:DATA_W];
        w_fin_lo = w_prod_s[DATA_W-1:0];
        if (r_is_div) begin
            w_fin_hi = r_neg_rem ? (~w_step_hi + {{(DATA_W-1){1'b0}}, 1'b1}) : w_step_hi;
            if (r_div_zero) begin
                w_fin_lo = {DATA_W{1'b1}};
            end else begin
                w_fin_lo = r_neg_res ? (~w_step_lo + {{(DATA_W-1){1'b0}}, 1'b1}) : w_step_lo;
            end
        end else begin
            w_fin_hi = w_prod_s[2*DATA_W-1:DATA_W];
            w_fin_lo = w_prod_s[DATA_W-1:0];
        end
    end

    // Mul/div datapath: capture at issue, iterate in RUN, commit HI/LO on the last cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= {CNT_W{1'b0}};
            r_acc_hi   <= {DATA_W{1'b0}};
            r_acc_lo   <= {DATA_W{1'b0}};
            r_opd      <= {DATA_W{1'b0}};
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= {DATA_W{1'b0}};
            r_lo       <= {DATA_W{1'b0}};
        end else if (w_md_start) begin
            r_cnt      <= CNT_LOAD;
            r_acc_hi   <= {DATA_W{1'b0}};
            r_acc_lo   <= w_op_div ? w_a_mag : w_b_mag;
            r_opd      <= w_op_div ? w_b_mag : w_a_mag;
            r_is_div   <= w_op_div;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_div_zero <= (w_b == {DATA_W{1'b0}});
        end else if (r_state == S_RUN) begin
            r_cnt    <= r_cnt - CNT_LAST;
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
            if (w_md_finish) begin
                r_hi <= w_fin_hi;
                r_lo <= w_fin_lo;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for the execute stage.
// - Combinational ALU/forwarding behaviour is checked from a vector table.
// - Mul/div latency, stalling, sign rules, divide-by-zero and reset-during-run are
//   checked in hand-written sequences.
module tb_ex_stage;

    localparam int DW = 32;
    localparam int N  = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    ex_ctrl;
    logic [5:0]    funct;
    logic [4:0]    shamt;
    logic [DW-1:0] reg1, reg2, sign_extend, mem_fwd_data, wb_fwd_data;
    logic [4:0]    rt, rd;
    logic [1:0]    fwd_a, fwd_b;
    logic [DW-1:0] alu_result, store_data, hi, lo;
    logic [4:0]    write_reg;
    logic          zero, md_stall;

    ex_stage #(.DATA_W(DW), .BITS_PC(1)) dut (
        .clk(clk), .rst(rst), .ex_ctrl(ex_ctrl), .funct(funct), .shamt(shamt),
        .reg1(reg1), .reg2(reg2), .sign_extend(sign_extend), .rt(rt), .rd(rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_data(wb_fwd_data), .alu_result(alu_result), .store_data(store_data),
        .write_reg(write_reg), .zero(zero), .md_stall(md_stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [5:0]  f;
        logic [4:0]  sh;
        logic [31:0] r1, r2, se;
        logic [1:0]  fa, fb;
        logic [31:0] mf, wf;
        logic [31:0] e_alu, e_store;
        logic [4:0]  e_wreg;
        logic        e_zero;
    } vec_t;

    vec_t        vt[24];
    int          nv = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cur_hi = 32'h0;
    logic [31:0] cur_lo = 32'h0;
    int          stall_cycles;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] se,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] mf, input logic [31:0] wf);
        ex_ctrl = c; funct = f; shamt = sh; reg1 = r1; reg2 = r2; sign_extend = se;
        fwd_a = fa; fwd_b = fb; mem_fwd_data = mf; wb_fwd_data = wf;
        rt = 5'd7; rd = 5'd9;
    endtask

    task automatic drive_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        drive(4'b1010, f, 5'd0, a, b, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic drive_nop();
        drive(4'b0000, 6'h00, 5'd0, 32'h1, 32'h2, 32'h3, 2'b00, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic add_vec(input logic [3:0] c, input logic [5:0] f, input logic [4:0] sh,
                           input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] se,
                           input logic [1:0] fa, input logic [1:0] fb,
                           input logic [31:0] mf, input logic [31:0] wf,
                           input logic [31:0] ea, input logic [31:0] es,
                           input logic [4:0] ew, input logic ez);
        vt[nv] = '{c, f, sh, r1, r2, se, fa, fb, mf, wf, ea, es, ew, ez};
        nv++;
    endtask

    // Issue a mul/div with independent instructions behind it; HI/LO must hold the
    // previous values through RUN cycle N and the new ones from cycle N+1.
    task automatic run_md(input string nm, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        logic any_stall;
        any_stall = 1'b0;
        drive_r(f, a, b);
        @(posedge clk); #1;
        drive_nop();
        repeat (N - 1) begin
            @(negedge clk);
            if (md_stall) any_stall = 1'b1;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({nm, "_hi_held"}, hi, cur_hi);
        chk({nm, "_lo_held"}, lo, cur_lo);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
        chk({nm, "_no_stall"}, {31'b0, any_stall}, 32'h0);
        cur_hi = eh;
        cur_lo = el;
        @(posedge clk); #1;
    endtask

    // Count cycles with md_stall high, bounded, starting from the current cycle
    task automatic count_stall(output int cycles);
        cycles = 0;
        @(negedge clk);
        while (md_stall && cycles < 3 * N) begin
            cycles++;
            @(posedge clk); #1;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Test sequence
    initial begin
        // ctrl = {RegDst, ALUSrc, ALUOp}; rt = 7, rd = 9
        add_vec(4'b1010, 6'h20, 5'd0, 32'h0000DEAD, 32'h3, 32'h0, 2'b10, 2'b00, 32'h5, 32'h0,
                32'h8, 32'h3, 5'd9, 1'b0);
        add_vec(4'b0100, 6'h00, 5'd0, 32'h10, 32'h99, 32'h4, 2'b00, 2'b01, 32'h0, 32'hA,
                32'h14, 32'hA, 5'd7, 1'b0);
        add_vec(4'b1010, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0,
                32'h1, 32'h1, 5'd9, 1'b0);
        add_vec(4'b1010, 6'h2B, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0,
                32'h0, 32'h1, 5'd9, 1'b1);
        add_vec(4'b1010, 6'h03, 5'd4, 32'h0, 32'h80000000, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0,
                32'hF8000000, 32'h80000000, 5'd9, 1'b0);
        add_vec(4'b1010, 6'h02, 5'd4, 32'h0, 32'h80000000, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0,
                32'h08000000, 32'h80000000, 5'd9, 1'b0);
        add_vec(4'b1010, 6'h00, 5'd31, 32'h0, 32'h1, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0,
                32'h80000000, 32'h1, 5'd9, 1'b0);
        add_vec(4'b0001, 6'h00, 5'd0, 32'h5, 32'h5, 32'h1234, 2'b00, 2'b00, 32'h0, 32'h0,
                32'h0, 32'h5, 5'd7, 1'b1);
        add_vec(4'b1010, 6'h24, 5'd0, 32'hF0F0, 32'hFF00, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0,
                32'hF000, 32'hFF00, 5'd9, 1'b0);
        add_vec(4'b1010, 6'h26, 5'd0, 32'hF0F0, 32'hFF00, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0,
                32'h0FF0, 32'hFF00, 5'd9, 1'b0);
        add_vec(4'b1010, 6'h27, 5'd0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0,
                32'hFFFFFFFF, 32'h0, 5'd9, 1'b0);
        add_vec(4'b0111, 6'h00, 5'd0, 32'h1200, 32'h55, 32'h34, 2'b00, 2'b00, 32'h0, 32'h0,
                32'h1234, 32'h55, 5'd7, 1'b0);
        add_vec(4'b1010, 6'h3F, 5'd0, 32'h1, 32'h5, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0,
                32'h0, 32'h5, 5'd9, 1'b1);
        add_vec(4'b1010, 6'h21, 5'd0, 32'h100, 32'h20, 32'h0, 2'b11, 2'b11, 32'hBAD, 32'hBAD,
                32'h120, 32'h20, 5'd9, 1'b0);
        add_vec(4'b1010, 6'h23, 5'd0, 32'h0, 32'h1, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0,
                32'hFFFFFFFF, 32'h1, 5'd9, 1'b0);
        add_vec(4'b1010, 6'h20, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 2'b00, 2'b10, 32'h2, 32'h0,
                32'h1, 32'h2, 5'd9, 1'b0);
        add_vec(4'b0100, 6'h00, 5'd0, 32'h100, 32'h77, 32'hFFFFFFFC, 2'b00, 2'b00, 32'h0, 32'h0,
                32'hFC, 32'h77, 5'd7, 1'b0);
        add_vec(4'b1010, 6'h10, 5'd0, 32'h1, 32'h2, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0,
                32'h0, 32'h2, 5'd9, 1'b1);

        // Reset
        rst = 1'b1;
        drive_nop();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_stall", {31'b0, md_stall}, 32'h0);

        // Combinational vectors
        for (int i = 0; i < nv; i++) begin
            @(posedge clk); #1;
            drive(vt[i].ctrl, vt[i].f, vt[i].sh, vt[i].r1, vt[i].r2, vt[i].se,
                  vt[i].fa, vt[i].fb, vt[i].mf, vt[i].wf);
            @(negedge clk);
            chk($sformatf("v%0d_alu", i), alu_result, vt[i].e_alu);
            chk($sformatf("v%0d_store", i), store_data, vt[i].e_store);
            chk($sformatf("v%0d_wreg", i), {27'b0, write_reg}, {27'b0, vt[i].e_wreg});
            chk($sformatf("v%0d_zero", i), {31'b0, zero}, {31'b0, vt[i].e_zero});
            chk($sformatf("v%0d_stall", i), {31'b0, md_stall}, 32'h0);
        end
        @(posedge clk); #1;

        // MULT -3*7 followed immediately by MFLO: stalls exactly N cycles
        drive_r(F_MULT, 32'hFFFFFFFD, 32'h7);
        @(posedge clk); #1;
        drive_r(F_MFLO, 32'h0, 32'h0);
        count_stall(stall_cycles);
        chk("mult_stall_cycles", stall_cycles, N);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);
        chk("mflo_result", alu_result, 32'hFFFFFFEB);
        cur_hi = 32'hFFFFFFFF;
        cur_lo = 32'hFFFFFFEB;
        @(posedge clk); #1;
        drive_nop();

        // Divides, including divide by zero, and an unsigned full-range multiply
        run_md("div_7_m2",    F_DIV,   32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD);
        run_md("divu_7_2",    F_DIVU,  32'h7,        32'h2,        32'h1,        32'h3);
        run_md("divu_by0",    F_DIVU,  32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF);
        run_md("div_m7_2",    F_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("div_by0_neg", F_DIV,   32'hFFFFFFF0, 32'h0,        32'hFFFFFFF0, 32'hFFFFFFFF);
        run_md("multu_max",   F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

        // MULTU followed back-to-back by DIVU: DIVU waits, then issues once IDLE
        drive_r(F_MULTU, 32'h00010000, 32'h00010000);
        @(posedge clk); #1;
        drive_r(F_DIVU, 32'd100, 32'd7);
        count_stall(stall_cycles);
        chk("b2b_stall_cycles", stall_cycles, N);
        chk("b2b_mul_hi", hi, 32'h1);
        chk("b2b_mul_lo", lo, 32'h0);
        @(posedge clk); #1;
        drive_nop();
        repeat (N) @(posedge clk);
        #1;
        @(negedge clk);
        chk("b2b_div_hi", hi, 32'd2);
        chk("b2b_div_lo", lo, 32'd14);
        @(posedge clk); #1;

        // Reset during RUN cycle 10 of a MULTU
        drive_r(F_MULTU, 32'h3, 32'h5);
        @(posedge clk); #1;
        drive_nop();
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_r(F_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_run_hi", hi, 32'h0);
        chk("rst_run_lo", lo, 32'h0);
        chk("rst_run_stall", {31'b0, md_stall}, 32'h0);
        chk("rst_run_mflo", alu_result, 32'h0);
        cur_hi = 32'h0;
        cur_lo = 32'h0;
        @(posedge clk); #1;
        run_md("mult_6_7", F_MULT, 32'h6, 32'h7, 32'h0, 32'h2A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
